// File: rtl/imu_spi_responder.sv
// SPI mode-3 target that stands in for the IMU: serves WHO_AM_I, R/W control bytes
// and a per-transaction snapshot of data_in, all oversampled in the clk domain.
module imu_spi_responder #(
    parameter logic [7:0] WHO_AM_I = 8'h6C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SPC,
    input  logic        CS,
    input  logic        SDI,
    output logic        SDO,
    input  logic [95:0] data_in,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

    state_t state, state_n;

    logic spc_s1, spc_s2, spc_d;
    logic cs_s1, cs_s2, cs_d;
    logic sdi_s1, sdi_s2;
    logic armed;

    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [6:0]        addr;
    logic [15:0][7:0]  ctrl;
    logic [11:0][7:0]  snapshot;

    logic       spc_rise, spc_fall, cs_fall, cs_rise;
    logic [7:0] shift_in;
    logic [6:0] rd_sel, snap_off;
    logic [3:0] snap_idx;
    logic [7:0] rd_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spc_s1 <= 1'b1; spc_s2 <= 1'b1; spc_d <= 1'b1;
            cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_d  <= 1'b1;
            sdi_s1 <= 1'b0; sdi_s2 <= 1'b0;
            armed  <= 1'b0;
        end else begin
            spc_s1 <= SPC; spc_s2 <= spc_s1; spc_d <= spc_s2;
            cs_s1  <= CS;  cs_s2  <= cs_s1;  cs_d  <= cs_s2;
            sdi_s1 <= SDI; sdi_s2 <= sdi_s1;
            // CS held low across reset must not look like a new frame
            armed  <= armed | (cs_s1 & cs_s2);
        end
    end

    assign spc_rise = spc_s2 & ~spc_d;
    assign spc_fall = ~spc_s2 & spc_d;
    assign cs_fall  = armed & cs_d & ~cs_s2;
    assign cs_rise  = cs_s2 & ~cs_d;
    assign busy     = ~cs_s2;
    assign shift_in = {shreg[6:0], sdi_s2};

    // In CMD the byte being completed is the start address of the read
    assign rd_sel   = (state == CMD) ? shift_in[6:0] : addr;
    assign snap_off = rd_sel - 7'h22;
    assign snap_idx = 4'd11 - snap_off[3:0];

    always_comb begin
        rd_byte = 8'h00;
        if (rd_sel == 7'h0F)
            rd_byte = WHO_AM_I;
        else if (rd_sel[6:4] == 3'b001)
            rd_byte = ctrl[rd_sel[3:0]];
        else if (rd_sel >= 7'h22 && rd_sel <= 7'h2D)
            rd_byte = snapshot[snap_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_n = CMD;
                CMD:     if (spc_rise && bit_cnt == 3'd7)
                             state_n = shift_in[7] ? READ : WRITE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            addr     <= 7'h00;
            ctrl     <= '0;
            snapshot <= '0;
            SDO      <= 1'b1;
            wr_valid <= 1'b0;
            wr_addr  <= 7'h00;
            wr_data  <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            if (cs_rise) begin
                bit_cnt <= 3'd0;
                SDO     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            snapshot <= data_in;
                            bit_cnt  <= 3'd0;
                            SDO      <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (spc_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                if (shift_in[7]) begin
                                    shreg <= rd_byte;
                                    addr  <= shift_in[6:0] + 7'd1;
                                end else begin
                                    addr  <= shift_in[6:0];
                                end
                            end
                        end
                    end
                    READ: begin
                        if (spc_fall) begin
                            SDO     <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                shreg <= rd_byte;
                                addr  <= addr + 7'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (spc_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr[6:4] == 3'b001) begin
                                    ctrl[addr[3:0]] <= shift_in;
                                    wr_valid        <= 1'b1;
                                    wr_addr         <= addr;
                                    wr_data         <= shift_in;
                                end
                                addr <= addr + 7'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imu_spi_responder.sv
// Directed bench for imu_spi_responder: bit-banged SPI mode-3 frames at 16x oversampling.
module tb_imu_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SPC = 1'b1;
    logic        CS = 1'b1;
    logic        SDI = 1'b0;
    logic        SDO;
    logic [95:0] data_in = '0;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int         wr_cnt = 0;
    logic [6:0] wr_addr_log [0:31];
    logic [7:0] wr_data_log [0:31];

    imu_spi_responder #(.WHO_AM_I(8'h6C)) dut (
        .clk(clk), .rst_n(rst_n), .SPC(SPC), .CS(CS), .SDI(SDI), .SDO(SDO),
        .data_in(data_in), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_valid) begin
            if (wr_cnt < 32) begin
                wr_addr_log[wr_cnt] = wr_addr;
                wr_data_log[wr_cnt] = wr_data;
            end
            wr_cnt++;
        end
    end

    task automatic spi_start();
        CS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (2) @(negedge clk);
        CS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Sends the top nbits of tx MSB first; rx holds SDO sampled just before each rising edge
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPC = 1'b0;
            SDI = tx[i];
            repeat (8) @(negedge clk);
            rx[i] = SDO;
            SPC = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SDO !== 1'b1)      begin errors++; $display("FAIL reset_sdo got %b want 1", SDO); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        checks++; if (wr_addr !== 7'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_whoami();
        logic [7:0] rx;
        int w0;
        w0 = wr_cnt;
        spi_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL whoami_busy_start got %b want 1", busy); end
        xfer(8'h8F, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h6C) begin errors++; $display("FAIL whoami_data got %h want 6c", rx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL whoami_busy_end got %b want 1", busy); end
        spi_end();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL whoami_busy_idle got %b want 0", busy); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL whoami_no_write got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_burst();
        logic [7:0] rx;
        data_in = 96'h0102030405060708090A0B0C;
        spi_start();
        xfer(8'hA2, 8, rx);
        data_in = 96'hFFEEDDCCBBAA998877665544;
        for (int b = 0; b < 12; b++) begin
            xfer(8'h00, 8, rx);
            checks++;
            if (rx !== 8'(b + 1)) begin
                errors++; $display("FAIL burst_byte%0d got %h want %h", b, rx, 8'(b + 1));
            end
        end
        spi_end();
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int w0;
        w0 = wr_cnt;
        spi_start();
        xfer(8'h10, 8, rx);
        xfer(8'hA5, 8, rx);
        xfer(8'h5A, 8, rx);
        spi_end();
        checks++; if (wr_cnt !== w0 + 2) begin errors++; $display("FAIL write_pulses got %0d want %0d", wr_cnt - w0, 2); end
        checks++; if (wr_addr_log[w0] !== 7'h10 || wr_data_log[w0] !== 8'hA5) begin
            errors++; $display("FAIL write_first got %h/%h want 10/a5", wr_addr_log[w0], wr_data_log[w0]); end
        checks++; if (wr_addr_log[w0+1] !== 7'h11 || wr_data_log[w0+1] !== 8'h5A) begin
            errors++; $display("FAIL write_second got %h/%h want 11/5a", wr_addr_log[w0+1], wr_data_log[w0+1]); end
        spi_start();
        xfer(8'h90, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL readback_10 got %h want a5", rx); end
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL readback_11 got %h want 5a", rx); end
        spi_end();
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int w0;
        w0 = wr_cnt;
        spi_start();
        xfer(8'h10, 8, rx);
        xfer(8'hFF, 5, rx);
        spi_end();
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_no_pulse got %0d want 0", wr_cnt - w0); end
        spi_start();
        xfer(8'h90, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL abort_reg_kept got %h want a5", rx); end
        spi_end();
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        int w0;
        // Seed 0x1F so the wrap read below has a non-zero neighbour
        spi_start();
        xfer(8'h1F, 8, rx);
        xfer(8'h3C, 8, rx);
        spi_end();
        spi_start();
        xfer(8'h9F, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL read_1f got %h want 3c", rx); end
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL read_20 got %h want 00", rx); end
        spi_end();
        spi_start();
        xfer(8'hFF, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_7f got %h want 00", rx); end
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_00 got %h want 00", rx); end
        spi_end();
        w0 = wr_cnt;
        spi_start();
        xfer(8'h7F, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        spi_end();
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL unmapped_write got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        spi_start();
        xfer(8'h90, 8, rx);
        xfer(8'h00, 4, rx);
        checks++; if (SDO !== 1'b0) begin errors++; $display("FAIL mid_sdo_bit3 got %b want 0", SDO); end
        rst_n = 1'b0;
        #1;
        checks++; if (SDO !== 1'b1) begin errors++; $display("FAIL mid_reset_sdo got %b want 1", SDO); end
        CS = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_start();
        xfer(8'h90, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL mid_ctrl_cleared got %h want 00", rx); end
        spi_end();
        spi_start();
        xfer(8'h8F, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h6C) begin errors++; $display("FAIL mid_whoami got %h want 6c", rx); end
        spi_end();
    endtask

    initial begin
        test_reset();
        test_whoami();
        test_burst();
        test_write();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
